// File: rtl/irq_controller_pkg.sv
// Shared definitions for the interrupt controller: register map, source
// limit, the interrupt level type and a byte-strobe helper.
package irq_controller_pkg;

    localparam int MAX_SRC = 16;
    localparam int LEVEL_W = 3;

    typedef logic [LEVEL_W-1:0] level_t;
    typedef logic [2:0]         reg_addr_t;

    localparam reg_addr_t REG_PENDING  = 3'd0;
    localparam reg_addr_t REG_ENABLE   = 3'd1;
    localparam reg_addr_t REG_MODE     = 3'd2;
    localparam reg_addr_t REG_POLARITY = 3'd3;
    localparam reg_addr_t REG_LEVEL0   = 3'd4;
    localparam reg_addr_t REG_LEVEL1   = 3'd5;
    localparam reg_addr_t REG_LEVEL2   = 3'd6;
    localparam reg_addr_t REG_LEVEL3   = 3'd7;

    // Expand the two byte strobes into a 16-bit per-bit write mask.
    function automatic logic [15:0] byte_mask(input logic [1:0] strobe);
        return {{8{strobe[1]}}, {8{strobe[0]}}};
    endfunction

endpackage

// File: rtl/irq_sync.sv
// Reset-clearable synchroniser for one asynchronous request line.
// STAGES = 0 bypasses the chain entirely.
module irq_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    generate
        if (STAGES == 0) begin : g_bypass
            logic unused_clk;
            assign unused_clk = clk ^ reset;
            assign q = d;
        end else begin : g_chain
            logic [STAGES-1:0] ff;

            // Shift the raw input through the flop chain.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    ff <= '0;
                end else begin
                    // NOTE: non-blocking, so every stage takes its
                    // neighbour's value from before this edge.
                    ff[0] <= d;
                    for (int k = 1; k < STAGES; k++) begin
                        ff[k] <= ff[k-1];
                    end
                end
            end

            assign q = ff[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/irq_controller.sv
// Prioritised interrupt controller: per-source synchroniser, polarity,
// edge/level capture, enable mask and 3-bit level, registered CPU level
// output and acknowledge-driven clearing of edge requests.
module irq_controller
    import irq_controller_pkg::*;
#(
    parameter int NUM_SRC     = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] src,
    input  logic [1:0]         wr,
    input  logic [2:0]         address,
    input  logic [15:0]        din,
    output logic [15:0]        dout,
    input  logic               iack,
    input  logic [2:0]         iack_level,
    output logic [2:0]         ipl
);

    logic [NUM_SRC-1:0] sync_q;
    logic [NUM_SRC-1:0] s;
    logic [NUM_SRC-1:0] prev_s;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] enable;
    logic [NUM_SRC-1:0] mode;
    logic [NUM_SRC-1:0] polarity;
    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] w1c;
    logic [NUM_SRC-1:0] iack_clr;
    logic [NUM_SRC-1:0] wm;
    logic [NUM_SRC-1:0] wdata;
    logic [15:0]        wmask;
    level_t             lvl [NUM_SRC];
    level_t             max_lvl;

    // Nibble bit 3 and data above NUM_SRC have no storage behind them.
    logic unused_bits;
    assign unused_bits = ^{din, wmask};

    // ------------------------------------------------------------------
    // Request conditioning
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_sync
        irq_sync #(
            .STAGES(SYNC_STAGES)
        ) u_sync (
            .clk  (clk),
            .reset(reset),
            .d    (src[i]),
            .q    (sync_q[i])
        );
    end

    assign s     = sync_q ^ polarity;
    assign rise  = s & ~prev_s;

    // ------------------------------------------------------------------
    // Register write decode
    // ------------------------------------------------------------------
    assign wmask = byte_mask(wr);
    assign wm    = wmask[NUM_SRC-1:0];
    assign wdata = din[NUM_SRC-1:0] & wm;
    assign w1c   = (address == REG_PENDING) ? wdata : '0;

    // Configuration registers: ENABLE, MODE, POLARITY and LEVEL fields.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enable   <= '0;
            mode     <= '0;
            polarity <= '0;
            // NOTE: the LEVEL fields are plain flops, not RAM, so they are
            // cleared by reset exactly like the bit registers.
            for (int i = 0; i < NUM_SRC; i++) begin
                lvl[i] <= '0;
            end
        end else begin
            if (address == REG_ENABLE) begin
                enable <= (enable & ~wm) | wdata;
            end
            if (address == REG_MODE) begin
                mode <= (mode & ~wm) | wdata;
            end
            if (address == REG_POLARITY) begin
                polarity <= (polarity & ~wm) | wdata;
            end
            for (int i = 0; i < NUM_SRC; i++) begin
                if ((address == 3'(int'(REG_LEVEL0) + i / 4)) && wr[(i % 4) / 2]) begin
                    lvl[i] <= din[4*(i % 4) +: LEVEL_W];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Eligibility, acknowledge target and highest requested level
    // ------------------------------------------------------------------

    // A source competes only when pending, enabled and given a level.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it
        // unassigned and no latch is inferred.
        eligible = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            eligible[i] = pending[i] & enable[i] & (lvl[i] != '0);
        end
    end

    // Pick the lowest-indexed eligible edge source at the acknowledged level.
    always_comb begin
        logic found;
        found    = 1'b0;
        iack_clr = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!found && iack && eligible[i] && !mode[i] && (lvl[i] == iack_level)) begin
                iack_clr[i] = 1'b1;
                found       = 1'b1;
            end
        end
    end

    // Maximum level among eligible sources; zero when nothing competes.
    always_comb begin
        max_lvl = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (eligible[i] && (lvl[i] > max_lvl)) begin
                max_lvl = lvl[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------

    // Edge history and PENDING: level sources track s, edge sources latch
    // rising edges and a new edge beats a same-cycle clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_s  <= '0;
            pending <= '0;
        end else begin
            prev_s  <= s;
            pending <= (mode & s) | (~mode & (rise | (pending & ~w1c & ~iack_clr)));
        end
    end

    // Registered CPU request level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ipl <= '0;
        end else begin
            ipl <= max_lvl;
        end
    end

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------

    // Combinational read of the addressed register, absent bits as zero.
    always_comb begin
        dout = '0;
        case (address)
            REG_PENDING:  dout[NUM_SRC-1:0] = pending;
            REG_ENABLE:   dout[NUM_SRC-1:0] = enable;
            REG_MODE:     dout[NUM_SRC-1:0] = mode;
            REG_POLARITY: dout[NUM_SRC-1:0] = polarity;
            default: begin
                for (int i = 0; i < NUM_SRC; i++) begin
                    if (address == 3'(int'(REG_LEVEL0) + i / 4)) begin
                        dout[4*(i % 4) +: LEVEL_W] = lvl[i];
                    end
                end
            end
        endcase
    end

endmodule

// File: doc/irq_controller.md
IRQ_CONTROLLER -- requirements
Module: irq_controller

Interface
REQ-001 Parameter NUM_SRC, default 3: number of interrupt sources, legal range 1..16.
REQ-002 Parameter SYNC_STAGES, default 2: synchroniser depth per source, legal range 0..3; 0 means no synchroniser.
REQ-003 clk  in  1  single system clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 src  in  NUM_SRC  raw interrupt request inputs, asynchronous to clk.
REQ-006 wr  in  2  byte write strobes: bit0 writes din[7:0], bit1 writes din[15:8].
REQ-007 address  in  3  register select.
REQ-008 din  in  16  write data.
REQ-009 dout  out  16  combinational read data for the addressed register.
REQ-010 iack  in  1  one-cycle interrupt acknowledge pulse.
REQ-011 iack_level  in  3  level being acknowledged, valid with iack.
REQ-012 ipl  out  3  registered, active-high requested CPU level; 0 means none.

Function
REQ-013 Register map:
- 0 = PENDING: read; write-1-to-clear.
- 1 = ENABLE: R/W.
- 2 = MODE: R/W; 1 = level, 0 = rising edge.
- 3 = POLARITY: R/W; 1 = invert src.
- 4..7 = LEVEL: R/W; 4 sources per register, nibble n = source 4*(addr-4)+n, bits[2:0] = level, bit3 reads 0.
REQ-014 Register bits at or above NUM_SRC, and LEVEL nibbles for absent sources, read 0 and ignore writes.
REQ-015 Each src bit passes through SYNC_STAGES flops, then XORs with POLARITY to form the conditioned request s[i].
REQ-016 Edge mode: s[i] high and previous s[i] low sets PENDING[i] on the same edge.
REQ-017 Level mode: PENDING[i] equals s[i] every cycle; PENDING writes and iack do not affect it.
REQ-018 Latency: with SYNC_STAGES=N, PENDING sets on the (N+1)th rising edge after src is first sampled active, and ipl updates on the following edge.
REQ-019 Source i is eligible when PENDING[i]=1, ENABLE[i]=1 and LEVEL[i]!=0.
REQ-020 ipl registers to the maximum LEVEL among eligible sources, or 0 when none are eligible.
REQ-021 iack clears PENDING of the lowest-indexed eligible edge-mode source whose LEVEL equals iack_level; at most one bit clears per iack.
REQ-022 iack with no matching eligible edge-mode source has no effect.
REQ-023 Simultaneous set and clear on one bit (edge vs. write-1 or iack): set wins.
REQ-024 A PENDING write and an iack in the same cycle both apply, each to its own target bit.
REQ-025 Disabling a source does not clear PENDING; re-enabling restores its eligibility.
REQ-026 Changing MODE from level to edge leaves PENDING at its current value.

Reset
REQ-027 Reset clears PENDING, ENABLE, MODE, POLARITY, all LEVEL fields, synchroniser flops, edge-history flops, and ipl.
REQ-028 Reset mid-operation aborts any request: ipl=0 asynchronously while reset is high.
REQ-029 After reset, an input already active is seen as a rising edge once it emerges from the synchroniser.

Structure
REQ-030 Package irq_controller_pkg holds:
- register address constants REG_PENDING..REG_LEVEL3;
- MAX_SRC=16;
- a 3-bit level typedef.
REQ-031 Sub-module irq_sync is an N-stage, reset-clearable synchroniser instantiated once per source.

Verification
REQ-032 Edge path: NUM_SRC=3, SYNC_STAGES=2, src0 LEVEL=1, enabled; pulse src[0] high -> PENDING=0x0001 after 3 edges, ipl=1 one edge later; iack with level 1 -> PENDING=0, ipl=0 next edge.
REQ-033 Priority: src0 level 1, src1 level 3, src2 level 3, all edge-pending -> ipl=3; iack level 3 clears bit1 only, ipl stays 3; second iack level 3 clears bit2, ipl=1.
REQ-034 Level mode: MODE=0x0004, src[2] held high -> PENDING bit2 stays 1 through iack and a write-1 of 0x0004; src low -> bit2 clears after 3 edges.
REQ-035 Collision: write 0x0001 to PENDING in the same cycle src0's synchronised edge arrives -> PENDING bit0 = 1.
REQ-036 Masking and polarity: ENABLE=0 with bit pending -> ipl=0, PENDING retained; POLARITY=0x0001 with src[0] idle low -> edge pending after sync.
REQ-037 Reset: assert reset with ipl=3 -> ipl=0 immediately; all registers read 0 after release.
